fir_coef_streamer: RTL and testbench



---
 rtl/fir_coef_if.sv | 27 ++
 rtl/fir_coef_streamer.sv | 134 +++++++++++++
 tb/tb_fir_coef_streamer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_coef_if.sv
// Coefficient-load bus between config logic and the FIR filters.
// Carries bank writes, burst start, the word stream and status.
interface fir_coef_if #(
  parameter int AW     = 2,
  parameter int DATA_W = 8
);
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              start;
  logic              coef_ready;
  logic [DATA_W-1:0] coef_val;
  logic              writeen;
  logic              tlast;
  logic              busy;
  logic              done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, coef_ready,
    input  coef_val, writeen, tlast, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, coef_ready,
    output coef_val, writeen, tlast, busy, done
  );
endinterface

// File: rtl/fir_coef_streamer.sv
// Streams a shadow coefficient bank to the FIR filters as one burst.
// Define FIR_COEF_SYM_EXPAND_EN to send the mirrored 2*N-1 word burst.
module fir_coef_streamer #(
  parameter int NUM_COEF = 4,
  parameter int DATA_W   = 8,
  parameter int AW       = 2
) (
  input logic       clk,
  input logic       rst_n,
  fir_coef_if.slave bus
);

  localparam int DEPTH = 1 << AW;
`ifdef FIR_COEF_SYM_EXPAND_EN
  localparam int LEN = 2 * NUM_COEF - 1;
`else
  localparam int LEN = NUM_COEF;
`endif
  localparam int IW = $clog2(LEN);
  localparam logic [IW-1:0] LASTI = IW'(LEN - 1);
  localparam logic [AW:0]   NCA   = (AW + 1)'(NUM_COEF);
`ifdef FIR_COEF_SYM_EXPAND_EN
  localparam logic [IW-1:0] NCI = IW'(NUM_COEF);
  localparam logic [IW-1:0] MIR = IW'(2 * NUM_COEF - 2);
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Burst position -> bank address (folds back in expanded mode).
  function automatic logic [AW-1:0] src_addr(input logic [IW-1:0] p);
`ifdef FIR_COEF_SYM_EXPAND_EN
    return (p < NCI) ? AW'(p) : AW'(MIR - p);
`else
    return AW'(p);
`endif
  endfunction

  logic [DATA_W-1:0] bank_q [DEPTH];
  logic [DATA_W-1:0] bank_d [DEPTH];
  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     idx_nx;
  logic [DATA_W-1:0] coef_val_q, coef_val_d;
  logic              writeen_q, writeen_d;
  logic              tlast_q, tlast_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_ok;

  assign we_ok  = bus.cfg_we & ~busy_q & ({1'b0, bus.cfg_addr} < NCA);
  assign idx_nx = idx_q + 1'b1;

  // Write is applied before word 0 is fetched, so a same-cycle
  // write+start sends the new value.
  always_comb begin
    bank_d = bank_q;
    if (we_ok) bank_d[bus.cfg_addr] = bus.cfg_data;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    coef_val_d = coef_val_q;
    writeen_d  = writeen_q;
    tlast_d    = tlast_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.start) begin
          state_d    = S_SEND;
          idx_d      = '0;
          busy_d     = 1'b1;
          writeen_d  = 1'b1;
          tlast_d    = 1'b0;
          coef_val_d = bank_d[src_addr('0)];
        end
      end
      (state_q == S_SEND): begin
        if (bus.coef_ready) begin
          if (idx_q == LASTI) begin
            state_d   = S_DONE;
            writeen_d = 1'b0;
            tlast_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            idx_d      = idx_nx;
            coef_val_d = bank_q[src_addr(idx_nx)];
            tlast_d    = (idx_nx == LASTI);
          end
        end
      end
      (state_q == S_DONE): begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      state_q    <= S_IDLE;
      idx_q      <= '0;
      coef_val_q <= '0;
      writeen_q  <= 1'b0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      coef_val_q <= coef_val_d;
      writeen_q  <= writeen_d;
      tlast_q    <= tlast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.coef_val = coef_val_q;
  assign bus.writeen  = writeen_q;
  assign bus.tlast    = tlast_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_fir_coef_streamer.sv
// Scoreboard bench for fir_coef_streamer (N=4, AW=3, DATA_W=8).
// Honours FIR_COEF_SYM_EXPAND_EN for burst length and order.
module tb_fir_coef_streamer;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 8;
`ifdef FIR_COEF_SYM_EXPAND_EN
  localparam int LEN = 2 * N - 1;
`else
  localparam int LEN = N;
`endif

  logic clk;
  logic rst_n;
  fir_coef_if #(.AW(AW), .DATA_W(DW)) bus ();

  fir_coef_streamer #(.NUM_COEF(N), .DATA_W(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  int          xfers;
  logic [DW-1:0] mb [N];
  logic [DW:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int src(input int p);
`ifdef FIR_COEF_SYM_EXPAND_EN
    return (p < N) ? p : 2 * N - 2 - p;
`else
    return p;
`endif
  endfunction

  // Every accepted word is popped against the scoreboard.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst_n) begin
      check("tlast_no_we", {31'd0, bus.tlast & ~bus.writeen}, 0);
      if (bus.writeen && bus.coef_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          check("extra_xfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("word", {bus.tlast, bus.coef_val}, e);
        end
      end
    end
  end

  task automatic wr(input int a, input logic [DW-1:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(a);
    bus.cfg_data = d;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    if (a < N) mb[a] = d;
  endtask

  task automatic push_burst();
    for (int p = 0; p < LEN; p++)
      exp_q.push_back({(p == LEN - 1), mb[src(p)]});
  endtask

  task automatic burst(input int stall_at, input int stall_n,
                       input bit poke, input bit wr_same,
                       input logic [DW-1:0] wd);
    int cyc;
    int stalled;
    bit seen;
    bit poked;
    if (wr_same) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = '0;
      bus.cfg_data = wd;
      mb[0] = wd;
    end
    push_burst();
    xfers = 0;
    bus.coef_ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    check("lat_we", {31'd0, bus.writeen}, 1);
    check("lat_w0", bus.coef_val, mb[src(0)]);
    check("lat_busy", {31'd0, bus.busy}, 1);
    cyc = 0; stalled = 0; seen = 0; poked = 0;
    repeat (60) begin
      if (xfers == stall_at && stalled < stall_n) begin
        bus.coef_ready = 1'b0;
        stalled++;
        check("hold", {bus.writeen, bus.coef_val}, {1'b1, mb[src(stall_at)]});
      end else begin
        bus.coef_ready = 1'b1;
      end
      if (poke && !poked && xfers == 1) begin
        poked = 1;
        bus.start    = 1'b1;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd1;
        bus.cfg_data = 8'hFF;
      end
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      cyc++;
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", {31'd0, seen}, 1);
    check("cycles", cyc, LEN + stall_n);
    check("xfers", xfers, LEN);
    check("q_empty", exp_q.size(), 0);
    check("busy_in_done", {31'd0, bus.busy}, 0);
    check("we_in_done", {31'd0, bus.writeen}, 0);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, bus.done}, 0);
    exp_q.delete();
  endtask

  initial begin
    n_vec = 0; n_err = 0; xfers = 0;
    for (int i = 0; i < N; i++) mb[i] = '0;
    rst_n = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.start = 1'b0; bus.coef_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_val", bus.coef_val, 0);
    check("rst_we", {31'd0, bus.writeen}, 0);
    check("rst_tlast", {31'd0, bus.tlast}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(3, 8'h44);
    burst(-1, 0, 0, 0, '0);
    burst(1, 3, 0, 0, '0);
    burst(-1, 0, 1, 0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("no_second_we", {31'd0, bus.writeen}, 0);
    check("no_second_busy", {31'd0, bus.busy}, 0);

    wr(5, 8'h99);
    burst(-1, 0, 0, 0, '0);
    burst(-1, 0, 0, 1, 8'h5A);

    wr(0, 8'h01); wr(1, 8'h02); wr(2, 8'h03); wr(3, 8'h04);
    burst(-1, 0, 0, 0, '0);

    // Abort a burst after word 1 has been accepted.
    push_burst();
    xfers = 0;
    bus.coef_ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) begin
      if (xfers >= 2) break;
      @(posedge clk); #1;
    end
    check("abort_xfers", xfers, 2);
    rst_n = 1'b0;
    #1;
    check("abort_we", {31'd0, bus.writeen}, 0);
    check("abort_tlast", {31'd0, bus.tlast}, 0);
    check("abort_busy", {31'd0, bus.busy}, 0);
    check("abort_val", bus.coef_val, 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) mb[i] = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    burst(-1, 0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
